// File: rtl/detect_sequencer.sv
// Receiver-detect sequencer: Detect.Quiet / Detect.Active for the PIPE tx path.
// Optional DETECT_RETRY_EN: one immediate re-detect before falling back to Quiet.
module detect_sequencer #(
  parameter int QUIET_CYCLES   = 1500000,
  parameter int ACTIVE_TIMEOUT = 64,
  parameter int CNT_W          = 21
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       detect_status,
  output logic       elec_idle_req,
  output logic       detect_req,
  output logic       detect_done,
  output logic [7:0] fail_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUIET = 3'd1,
    S_AREQ  = 3'd2,
    S_AWAIT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ACTIVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_ZERO = '0;
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_t           st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       fail_nx;

`ifdef DETECT_RETRY_EN
  logic retry_q, retry_nx;
`endif

  assign state = st;

  // next-state, counter and failure-count decode; start=0 overrides all
  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    fail_nx = fail_cnt;
`ifdef DETECT_RETRY_EN
    retry_nx = retry_q;
`endif
    if (!start) begin
      st_nx  = S_IDLE;
      cnt_nx = C_ZERO;
`ifdef DETECT_RETRY_EN
      retry_nx = 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          st_nx  = S_QUIET;
          cnt_nx = C_ZERO;
        end
        S_QUIET: begin
          if (cnt == Q_LAST) begin
            st_nx  = S_AREQ;
            cnt_nx = C_ZERO;
          end else begin
            cnt_nx = cnt + C_ONE;
          end
        end
        S_AREQ: begin
          st_nx  = S_AWAIT;
          cnt_nx = C_ZERO;
        end
        S_AWAIT: begin
          if (detect_status) begin
            st_nx  = S_DONE;
            cnt_nx = C_ZERO;
`ifdef DETECT_RETRY_EN
            retry_nx = 1'b0;
`endif
          end else if (cnt == A_LAST) begin
            cnt_nx = C_ZERO;
            if (fail_cnt != 8'hFF)
              fail_nx = fail_cnt + 8'd1;
`ifdef DETECT_RETRY_EN
            if (!retry_q) begin
              retry_nx = 1'b1;
              st_nx    = S_AREQ;
            end else begin
              retry_nx = 1'b0;
              st_nx    = S_QUIET;
            end
`else
            st_nx = S_QUIET;
`endif
          end else begin
            cnt_nx = cnt + C_ONE;
          end
        end
        S_DONE: begin
          cnt_nx = C_ZERO;
        end
        default: begin
          st_nx  = S_IDLE;
          cnt_nx = C_ZERO;
`ifdef DETECT_RETRY_EN
          retry_nx = 1'b0;
`endif
        end
      endcase
    end
  end

  // state register with outputs decoded from the next state
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= S_IDLE;
      cnt           <= C_ZERO;
      fail_cnt      <= 8'd0;
      elec_idle_req <= 1'b1;
      detect_req    <= 1'b0;
      detect_done   <= 1'b0;
    end else begin
      st            <= st_nx;
      cnt           <= cnt_nx;
      fail_cnt      <= fail_nx;
      elec_idle_req <= (st_nx != S_DONE);
      detect_req    <= (st_nx == S_AREQ);
      detect_done   <= (st_nx == S_DONE);
    end
  end

`ifdef DETECT_RETRY_EN
  // retry flag: set on first timeout of an attempt
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n)
      retry_q <= 1'b0;
    else
      retry_q <= retry_nx;
  end
`endif

endmodule

// File: doc/detect_sequencer.md
# detect_sequencer

Link-training front end driving the receiver-detect phase of the PIPE transmit path. Sequences Detect.Quiet and Detect.Active and feeds the PIPE control stage directly downstream: drives its electrical-idle request and detect request, and consumes its registered detect status. On a successful detect it holds a done flag for the Polling logic. On failure it returns to Quiet and counts attempts.

## Interface
Parameters:
- QUIET_CYCLES, 1500000, pclk cycles spent in QUIET (12 ms at 125 MHz); must be ≥2.
- ACTIVE_TIMEOUT, 64, pclk cycles ACTIVE_WAIT waits for detect_status before declaring failure; must be ≥2.
- CNT_W, 21, width of the shared cycle counter; must hold max(QUIET_CYCLES, ACTIVE_TIMEOUT)-1.

Ports:
- pclk  in  1  PIPE clock. Single clock domain.
- reset_n  in  1  Asynchronous, active-low reset.
- start  in  1  Level. High enables detect sequencing; low aborts to IDLE from any state.
- detect_status  in  1  Receiver-detected indication from the PIPE control stage, sampled only in ACTIVE_WAIT.
- elec_idle_req  out  1  Request transmitter electrical idle.
- detect_req  out  1  Single-cycle receiver-detect request.
- detect_done  out  1  Level. Receiver detected; Polling may begin.
- fail_cnt  out  8  Saturating count of Detect.Active timeouts since reset.
- state  out  3  Current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, QUIET=1, ACTIVE_REQ=2, ACTIVE_WAIT=3, DONE=4. Other encodings are unreachable and recover to IDLE.
- Reset values: state=IDLE, counter=0, elec_idle_req=1, detect_req=0, detect_done=0, fail_cnt=0, retry flag=0.
- IDLE: wait for start=1, then go to QUIET with counter=0.
- QUIET: counter increments each cycle. When counter==QUIET_CYCLES-1, go to ACTIVE_REQ.
- ACTIVE_REQ: lasts one cycle. Go to ACTIVE_WAIT with counter=0.
- ACTIVE_WAIT: counter increments each cycle.
  - detect_status=1: go to DONE.
  - Otherwise, when counter==ACTIVE_TIMEOUT-1 it is a timeout: fail_cnt increments (saturates at 255) and the state goes to QUIET with counter=0. With DETECT_RETRY_EN, see Configuration.
- DONE: hold until start=0.
- start=0 in any state: next state is IDLE, counter=0, retry flag cleared. This has priority over every other transition. fail_cnt is not cleared.
- Output decode, all registered as a function of next state:
  - elec_idle_req=1 in every state except DONE.
  - detect_req=1 only in ACTIVE_REQ.
  - detect_done=1 only in DONE.
- Simultaneous detect_status=1 and timeout in ACTIVE_WAIT: detect wins. Go to DONE, no fail_cnt increment.
- detect_status outside ACTIVE_WAIT is ignored.
- Counter arithmetic is unsigned CNT_W bits. It is cleared on every state entry and never wraps within a state.

## Timing
- Outputs are registered and change on the pclk edge on which the state changes.
- start rising seen at edge k: QUIET from k, ACTIVE_REQ at edge k+QUIET_CYCLES, detect_req high for exactly one cycle, ACTIVE_WAIT at k+QUIET_CYCLES+1.
- detect_status high at edge m in ACTIVE_WAIT: detect_done=1 and elec_idle_req=0 from edge m.
- Failure: ACTIVE_WAIT lasts exactly ACTIVE_TIMEOUT cycles; fail_cnt updates on the exit edge.
- The downstream stage registers detect_req, so detect_status arrives no earlier than 2 cycles after detect_req. ACTIVE_TIMEOUT must cover the PHY's PhyStatus latency.
- Asynchronous reset mid-sequence forces reset values immediately. Sequencing restarts from IDLE on the first edge after release with start=1.

## Configuration
- DETECT_RETRY_EN defined:
  - First timeout of an attempt sets the retry flag and goes straight to ACTIVE_REQ, with no Quiet period.
  - A second consecutive timeout clears the flag and goes to QUIET.
  - fail_cnt increments on both timeouts.
  - Entering DONE or IDLE clears the flag.
- DETECT_RETRY_EN undefined: no retry flag exists; every timeout goes to QUIET.

## Test plan
Benches override QUIET_CYCLES=8, ACTIVE_TIMEOUT=4 unless stated.
- Reset then start=1: elec_idle_req=1 throughout; detect_req single pulse exactly 8 cycles after start; state sequence 1→2→3.
- detect_status=1 on the 2nd ACTIVE_WAIT cycle: detect_done=1 and elec_idle_req=0 on that edge, fail_cnt=0, state=4 held.
- detect_status never asserted, macro undefined: fail_cnt increments every 13 cycles (8+1+4), with a detect_req pulse each loop; after 300 loops fail_cnt=255 (saturated).
- Macro defined, no detect: two detect_req pulses 5 cycles apart, then 8 Quiet cycles; fail_cnt +2 per loop.
- detect_status=1 on the final ACTIVE_WAIT cycle (counter=3): state=DONE, fail_cnt unchanged. Then start=0 in DONE: state=IDLE, detect_done=0, elec_idle_req=1 next edge.
- reset_n low mid-QUIET and mid-ACTIVE_WAIT: all outputs return to reset values immediately; re-release with start=1 restarts the full 8-cycle Quiet.
